vga_pixel_fetch: RTL and testbench

VGA_PIXEL_FETCH -- requirements
Module: vga_pixel_fetch

---
 rtl/vga_pixel_fetch.sv | 197 +++++++++++++++++++
 tb/tb_vga_pixel_fetch.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_pixel_fetch.sv
`default_nettype none
// ============================================================================
// Module   : vga_pixel_fetch
// Brief    : Double-buffered 320x240 (2x scaled) RGB332 framebuffer fetch for a
//            640x480 VGA raster, with sync/blank realigned to the pixel pipeline.
//            Optional macro PIX_FETCH_TEST_PATTERN_EN adds a colour-bar source.
// Revision : 1.0  initial release
// ============================================================================
module vga_pixel_fetch #(
    parameter int MEM_LAT = 2          // framebuffer read latency, 1..4 clocks
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [9:0]  hcont,
    input  logic [9:0]  vcont,
    input  logic        hsync_i,
    input  logic        vsync_i,
    input  logic        blank_i,
    input  logic        swap_req,
`ifdef PIX_FETCH_TEST_PATTERN_EN
    input  logic        test_mode,
`endif
    input  logic [7:0]  mem_data,
    output logic [17:0] mem_addr,
    output logic        mem_rd,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        hsync_o,
    output logic        vsync_o,
    output logic        blank_o,
    output logic        front_bank,
    output logic        swap_ack
);

    localparam int c_LAT = MEM_LAT + 2;
    // Stage of each delay line that is aligned with the pixel capture edge.
    localparam int c_MID = c_LAT - 2;

    logic              w_active;
    logic              w_rd_en;
    logic [8:0]        w_x;
    logic [17:0]       w_bank_base;
    logic              w_flip;
    logic [11:0]       w_mem_rgb;
    logic [11:0]       w_pix_rgb;

    logic [16:0]       r_row_base;
    logic [17:0]       r_mem_addr;
    logic              r_mem_rd;
    logic [c_LAT-1:0]  r_hs_sr;
    logic [c_LAT-1:0]  r_vs_sr;
    logic [c_LAT-1:0]  r_bl_sr;
    logic [c_MID:0]    r_act_sr;
    logic [11:0]       r_rgb;
    logic              r_front_bank;
    logic              r_swap_ack;
    logic              r_flip_done;

    always_comb begin
        w_active    = (hcont < 10'd640) && (vcont < 10'd480);
        w_x         = hcont[9:1];
        w_bank_base = r_front_bank ? 18'd76800 : 18'd0;
        w_flip      = (vcont == 10'd480) && (hcont == 10'd0) && swap_req && !r_flip_done;
        w_mem_rgb   = {mem_data[7:5], mem_data[7],
                       mem_data[4:2], mem_data[4],
                       mem_data[1:0], mem_data[1:0]};
    end

`ifdef PIX_FETCH_TEST_PATTERN_EN
    logic [2:0] w_bar;
    logic [2:0] r_bar_sr [0:c_MID];
    logic [c_MID:0] r_tm_sr;

    // 80-pixel bars: index is hcont/80, resolved with compares instead of a divider.
    always_comb begin
        w_bar = 3'd7;
        if      (hcont < 10'd80)  w_bar = 3'd0;
        else if (hcont < 10'd160) w_bar = 3'd1;
        else if (hcont < 10'd240) w_bar = 3'd2;
        else if (hcont < 10'd320) w_bar = 3'd3;
        else if (hcont < 10'd400) w_bar = 3'd4;
        else if (hcont < 10'd480) w_bar = 3'd5;
        else if (hcont < 10'd560) w_bar = 3'd6;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_tm_sr <= '0;
            for (int i = 0; i <= c_MID; i++) begin
                r_bar_sr[i] <= 3'd0;
            end
        end else begin
            r_tm_sr    <= {r_tm_sr[c_MID-1:0], test_mode};
            r_bar_sr[0] <= w_bar;
            for (int i = 1; i <= c_MID; i++) begin
                r_bar_sr[i] <= r_bar_sr[i-1];
            end
        end
    end

    always_comb begin
        w_rd_en   = w_active && !test_mode;
        w_pix_rgb = w_mem_rgb;
        if (r_tm_sr[c_MID]) begin
            w_pix_rgb = {{4{r_bar_sr[c_MID][2]}},
                         {4{r_bar_sr[c_MID][1]}},
                         {4{r_bar_sr[c_MID][0]}}};
        end
    end
`else
    always_comb begin
        w_rd_en   = w_active;
        w_pix_rgb = w_mem_rgb;
    end
`endif

    // Row base advances after each odd line so two scan lines share one row.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_row_base <= '0;
        end else if (vcont >= 10'd480) begin
            r_row_base <= '0;
        end else if ((hcont == 10'd640) && vcont[0]) begin
            r_row_base <= r_row_base + 17'd320;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_mem_addr <= '0;
            r_mem_rd   <= 1'b0;
        end else begin
            r_mem_rd <= w_rd_en;
            if (w_rd_en) begin
                r_mem_addr <= w_bank_base + {1'b0, r_row_base} + {9'd0, w_x};
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_hs_sr  <= '1;
            r_vs_sr  <= '1;
            r_bl_sr  <= '0;
            r_act_sr <= '0;
        end else begin
            r_hs_sr  <= {r_hs_sr[c_LAT-2:0], hsync_i};
            r_vs_sr  <= {r_vs_sr[c_LAT-2:0], vsync_i};
            r_bl_sr  <= {r_bl_sr[c_LAT-2:0], blank_i};
            r_act_sr <= {r_act_sr[c_MID-1:0], w_active};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rgb <= '0;
        end else if (r_act_sr[c_MID] && r_bl_sr[c_MID]) begin
            r_rgb <= w_pix_rgb;
        end else begin
            r_rgb <= '0;
        end
    end

    // r_flip_done re-arms once the raster is back in the visible area,
    // so a held request flips only once per frame.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_front_bank <= 1'b0;
            r_swap_ack   <= 1'b0;
            r_flip_done  <= 1'b0;
        end else begin
            r_swap_ack <= w_flip;
            if (w_flip) begin
                r_front_bank <= ~r_front_bank;
            end
            if (vcont < 10'd480) begin
                r_flip_done <= 1'b0;
            end else if (w_flip) begin
                r_flip_done <= 1'b1;
            end
        end
    end

    assign mem_addr   = r_mem_addr;
    assign mem_rd     = r_mem_rd;
    assign vga_r      = r_rgb[11:8];
    assign vga_g      = r_rgb[7:4];
    assign vga_b      = r_rgb[3:0];
    assign hsync_o    = r_hs_sr[c_LAT-1];
    assign vsync_o    = r_vs_sr[c_LAT-1];
    assign blank_o    = r_bl_sr[c_LAT-1];
    assign front_bank = r_front_bank;
    assign swap_ack   = r_swap_ack;

endmodule
`default_nettype wire

// File: tb/tb_vga_pixel_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_pixel_fetch
// Brief    : Randomized raster stimulus for vga_pixel_fetch against a
//            reference model of addresses, pipeline delays and buffer flips.
// Revision : 1.0  initial release
// ============================================================================
module tb_vga_pixel_fetch;

    localparam int MEM_LAT = 2;
    localparam int L       = MEM_LAT + 2;

    logic        clock;
    logic        reset;
    logic [9:0]  hcont, vcont;
    logic        hsync_i, vsync_i, blank_i, swap_req, test_mode;
    logic [7:0]  mem_data;
    logic [17:0] mem_addr;
    logic        mem_rd;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic        hsync_o, vsync_o, blank_o, front_bank, swap_ack;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 16;
    int flip_cnt = 0;
    bit tm_en   = 1'b0;

    // Per-cycle history of inputs and expectations, indexed by cycle mod 16.
    bit          h_act [16];
    bit          h_rd  [16];
    bit          h_tm  [16];
    bit          h_hs  [16];
    bit          h_vs  [16];
    bit          h_bl  [16];
    logic [9:0]  h_h   [16];
    logic [17:0] h_addr[16];
    logic [17:0] h_dut_addr[16];
    logic        h_dut_rd  [16];

    bit          e_bank, e_ack, m_armed;
    logic [17:0] m_last_addr;

    vga_pixel_fetch #(.MEM_LAT(MEM_LAT)) dut (
        .clock      (clock),
        .reset      (reset),
        .hcont      (hcont),
        .vcont      (vcont),
        .hsync_i    (hsync_i),
        .vsync_i    (vsync_i),
        .blank_i    (blank_i),
        .swap_req   (swap_req),
`ifdef PIX_FETCH_TEST_PATTERN_EN
        .test_mode  (test_mode),
`endif
        .mem_data   (mem_data),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .vga_r      (vga_r),
        .vga_g      (vga_g),
        .vga_b      (vga_b),
        .hsync_o    (hsync_o),
        .vsync_o    (vsync_o),
        .blank_o    (blank_o),
        .front_bank (front_bank),
        .swap_ack   (swap_ack)
    );

    initial clock = 1'b0;
    always #20 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [7:0] memf(input logic [17:0] a);
        return a[7:0] ^ a[15:8] ^ {a[17:16], 6'd0} ^ 8'h5A;
    endfunction

    function automatic logic [11:0] expand(input logic [7:0] d);
        return {d[7:5], d[7], d[4:2], d[4], d[1:0], d[1:0]};
    endfunction

    function automatic logic [11:0] pat(input logic [9:0] h);
        int b;
        b = int'(h) / 80;
        return {(b[2] ? 4'hF : 4'h0), (b[1] ? 4'hF : 4'h0), (b[0] ? 4'hF : 4'h0)};
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        hcont = 10'd700; vcont = 10'd500;
        hsync_i = 1'b1; vsync_i = 1'b1; blank_i = 1'b0;
        swap_req = 1'b0; test_mode = 1'b0; mem_data = 8'd0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_rd", mem_rd, 0);
        check("rst_rgb", {vga_r, vga_g, vga_b}, 0);
        check("rst_front_bank", front_bank, 0);
        check("rst_swap_ack", swap_ack, 0);
        check("rst_blank_o", blank_o, 0);
        check("rst_hsync_o", hsync_o, 1);
        check("rst_vsync_o", vsync_o, 1);
        for (int i = 0; i < 16; i++) begin
            h_act[i] = 0; h_rd[i] = 0; h_tm[i] = 0;
            h_hs[i] = 1; h_vs[i] = 1; h_bl[i] = 0;
            h_h[i] = 10'd700; h_addr[i] = '0;
            h_dut_addr[i] = '0; h_dut_rd[i] = 1'b0;
        end
        e_bank = 0; e_ack = 0; m_armed = 1; m_last_addr = '0;
        reset = 1'b0;
    endtask

    task automatic step(input logic [9:0] h, input logic [9:0] v, input logic sr);
        int c, p, d, m, a;
        bit fl;
        logic [11:0] erg;
        @(posedge clock);
        #1;
        cyc++;
        c = cyc & 15; p = (cyc - 1) & 15; d = (cyc - L) & 15; m = (cyc - MEM_LAT) & 15;

        if (h_rd[p]) m_last_addr = h_addr[p];
        check("mem_rd", mem_rd, h_rd[p]);
        check("mem_addr", mem_addr, m_last_addr);
        check("front_bank", front_bank, e_bank);
        check("swap_ack", swap_ack, e_ack);
        if (swap_ack) flip_cnt++;
        check("hsync_o", hsync_o, h_hs[d]);
        check("vsync_o", vsync_o, h_vs[d]);
        check("blank_o", blank_o, h_bl[d]);
        if (!(h_act[d] && h_bl[d])) erg = 12'h000;
        else if (h_tm[d])           erg = pat(h_h[d]);
        else                        erg = expand(memf(h_addr[d]));
        check("rgb", {vga_r, vga_g, vga_b}, erg);

        // Framebuffer model: answers the address issued MEM_LAT cycles ago.
        h_dut_addr[c] = mem_addr;
        h_dut_rd[c]   = mem_rd;
        mem_data = h_dut_rd[m] ? memf(h_dut_addr[m]) : 8'($urandom);

        hcont = h; vcont = v; swap_req = sr;
        hsync_i = 1'($urandom); vsync_i = 1'($urandom);
        blank_i = (($urandom % 8) != 0);
        test_mode = tm_en ? 1'($urandom) : 1'b0;

        a = (e_bank ? 76800 : 0) + 320 * (int'(v) / 2) + int'(h) / 2;
        h_act[c]  = (h < 640) && (v < 480);
        h_rd[c]   = h_act[c] && !test_mode;
        h_tm[c]   = test_mode;
        h_hs[c]   = hsync_i; h_vs[c] = vsync_i; h_bl[c] = blank_i;
        h_h[c]    = h;
        h_addr[c] = 18'(a);

        if (v < 480) m_armed = 1;
        fl = (v == 480) && (h == 0) && sr && m_armed;
        if (fl) m_armed = 0;
        e_ack  = fl;
        e_bank = e_bank ^ fl;
    endtask

    task automatic vblank(input logic sr);
        step(10'd0,   10'd480, sr);
        step(10'd0,   10'd480, sr);
        step(10'd5,   10'd480, sr);
        step(10'd700, 10'd490, sr);
        step(10'd0,   10'd524, sr);
    endtask

    task automatic run_frame(input logic sr, input int nlines);
        logic [9:0] hv;
        for (int v = 0; v < nlines; v++) begin
            if (v == 0)   step(10'd0,   10'd0,   sr);
            if (v == 3)   step(10'd5,   10'd3,   sr);
            if (v == 479) step(10'd639, 10'd479, sr);
            repeat (3) begin
                hv = (($urandom % 6) == 0) ? 10'($urandom_range(641, 799))
                                           : 10'($urandom_range(0, 639));
                step(hv, 10'(v), sr);
            end
            step(10'd640, 10'(v), sr);
        end
        if (nlines == 480) vblank(sr);
    endtask

    initial begin
        do_reset();
        vblank(1'b0);
        run_frame(1'b1, 480);
        run_frame(1'b1, 480);
        check("flip_count_held_req", flip_cnt, 2);
        run_frame(1'b0, 480);
        check("flip_count_no_req", flip_cnt, 2);
        run_frame(1'b1, 100);
        do_reset();
        vblank(1'b0);
        run_frame(1'($urandom), 480);
`ifdef PIX_FETCH_TEST_PATTERN_EN
        tm_en = 1'b1;
        run_frame(1'b0, 60);
        tm_en = 1'b0;
        run_frame(1'b0, 8);
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
